bcd_digit_accumulator: RTL and testbench

Consumes the stream of 4-bit decimal digit codes produced by the decimal-to-binary encoder stage, one digit per handshake, most significant digit first. Accumulates them into a single unsigned binary number (acc = acc*10 + digit). Presents the completed number on a valid/ready output handshake. Sits directly downstream of the digit encoder, between keypad/digit entry and the numeric datapath.

---
 rtl/bcd_pkg.sv | 11 +
 rtl/bcd_digit_accumulator_mul10_add.sv | 14 +
 rtl/bcd_digit_accumulator.sv | 95 +++++++++
 tb/tb_bcd_digit_accumulator.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD digit accumulator.
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/bcd_digit_accumulator_mul10_add.sv
// Combinational acc*10 + digit, built from shifts so no multiplier is inferred.
module mul10_add
  import bcd_pkg::*;
#(
  parameter int OUT_W = 14
) (
  input  logic [OUT_W-1:0]   acc,
  input  logic [DIGIT_W-1:0] digit,
  output logic [OUT_W-1:0]   result
);
  always_comb begin
    result = (acc << 3) + (acc << 1) + OUT_W'(digit);
  end
endmodule

// File: rtl/bcd_digit_accumulator.sv
// Accumulates an MSD-first decimal digit stream into a binary number and
// presents it on a valid/ready output.
module bcd_digit_accumulator
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int OUT_W      = 14,
  parameter int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  output logic               digit_ready,
  input  logic               enter,
  input  logic               clear,
  output logic               value_valid,
  input  logic               value_ready,
  output logic [OUT_W-1:0]   value,
  output logic [CNT_W-1:0]   digit_count,
  output logic               err
);
  state_t             state;
  logic [OUT_W-1:0]   acc;
  logic [OUT_W-1:0]   acc_next;
  logic [CNT_W-1:0]   count;
  logic               accept;
  logic               legal;

  mul10_add #(.OUT_W(OUT_W)) u_mul10_add (
    .acc    (acc),
    .digit  (digit),
    .result (acc_next)
  );

  assign digit_ready = (state != DONE);
  assign accept      = digit_valid & digit_ready;
  assign legal       = (digit <= MAX_DIGIT);
  assign value       = acc;
  assign digit_count = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      count       <= '0;
      value_valid <= 1'b0;
      err         <= 1'b0;
    end else if (clear) begin
      // Any accept in this cycle is dropped, including its error pulse.
      state       <= IDLE;
      acc         <= '0;
      count       <= '0;
      value_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE, ACCUM: begin
          if (accept && legal) begin
            acc   <= acc_next;
            count <= count + 1'b1;
            if ((count + 1'b1 == CNT_W'(NUM_DIGITS)) || enter) begin
              state       <= DONE;
              value_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end else begin
            if (accept) err <= 1'b1;
            // A commit needs at least one digit, so enter in IDLE is ignored.
            if (enter && state == ACCUM) begin
              state       <= DONE;
              value_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (value_ready) begin
            state       <= IDLE;
            acc         <= '0;
            count       <= '0;
            value_valid <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          acc         <= '0;
          count       <= '0;
          value_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_digit_accumulator.sv
// Scoreboard bench for bcd_digit_accumulator: expected numbers are queued as
// digits are driven and checked when value_valid rises.
module tb_bcd_digit_accumulator;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit = 4'd0;
  logic        digit_ready;
  logic        enter = 1'b0;
  logic        clear = 1'b0;
  logic        value_valid;
  logic        value_ready = 1'b0;
  logic [13:0] value;
  logic [2:0]  digit_count;
  logic        err;

  typedef struct {
    logic [13:0] v;
    logic [2:0]  c;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  logic prev_vv = 1'b0;

  bcd_digit_accumulator dut (
    .clk         (clk),
    .rst         (rst),
    .digit_valid (digit_valid),
    .digit       (digit),
    .digit_ready (digit_ready),
    .enter       (enter),
    .clear       (clear),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .value       (value),
    .digit_count (digit_count),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Monitor: compare each new number against the head of the scoreboard.
  always @(negedge clk) begin
    if (value_valid && !prev_vv) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL sb_unexpected: got value=%0d count=%0d, required no output", value, digit_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (value !== e.v || digit_count !== e.c) begin
          mismatched++;
          $display("FAIL sb_value: got value=%0d count=%0d, required value=%0d count=%0d",
                   value, digit_count, e.v, e.c);
        end
      end
    end
    prev_vv = value_valid;
  end

  task automatic send_digit(input logic [3:0] d, input logic en);
    digit_valid = 1'b1;
    digit       = d;
    enter       = en;
    @(posedge clk); #1;
    digit_valid = 1'b0;
    enter       = 1'b0;
  endtask

  task automatic pulse_enter();
    enter = 1'b1;
    @(posedge clk); #1;
    enter = 1'b0;
  endtask

  task automatic release_value();
    value_ready = 1'b1;
    @(posedge clk); #1;
    value_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    compared++;
    if (value_valid !== 1'b0 || value !== 14'd0 || digit_count !== 3'd0 ||
        err !== 1'b0 || digit_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset: got vv=%b value=%0d count=%0d err=%b ready=%b, required 0 0 0 0 1",
               value_valid, value, digit_count, err, digit_ready);
    end
  endtask

  task automatic test_four_digits();
    exp_q.push_back('{14'h04D2, 3'd4});
    send_digit(4'd1, 1'b0);
    send_digit(4'd2, 1'b0);
    send_digit(4'd3, 1'b0);
    send_digit(4'd4, 1'b0);
    @(negedge clk);
    compared++;
    if (value_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL autocommit_latency: got vv=%b, required 1", value_valid);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (value_valid !== 1'b1 || digit_ready !== 1'b0 || digit_count !== 3'd4 || value !== 14'd1234) begin
      mismatched++;
      $display("FAIL done_hold: got vv=%b ready=%b count=%0d value=%0d, required 1 0 4 1234",
               value_valid, digit_ready, digit_count, value);
    end
    release_value();
    @(negedge clk);
    compared++;
    if (value_valid !== 1'b0 || digit_count !== 3'd0 || digit_ready !== 1'b1 || value !== 14'd0) begin
      mismatched++;
      $display("FAIL done_release: got vv=%b count=%0d ready=%b value=%0d, required 0 0 1 0",
               value_valid, digit_count, digit_ready, value);
    end
  endtask

  task automatic test_enter();
    exp_q.push_back('{14'd42, 3'd2});
    send_digit(4'd4, 1'b0);
    send_digit(4'd2, 1'b0);
    @(negedge clk);
    compared++;
    if (value_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL partial_no_commit: got vv=%b, required 0", value_valid);
    end
    pulse_enter();
    @(negedge clk);
    compared++;
    if (value_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL enter_commit: got vv=%b, required 1", value_valid);
    end
    release_value();
    // enter alone in IDLE must not commit an empty number.
    pulse_enter();
    @(negedge clk);
    compared++;
    if (value_valid !== 1'b0 || digit_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL enter_idle: got vv=%b ready=%b, required 0 1", value_valid, digit_ready);
    end
    exp_q.push_back('{14'd7, 3'd1});
    send_digit(4'd7, 1'b1);
    @(negedge clk);
    compared++;
    if (value_valid !== 1'b1 || digit_count !== 3'd1) begin
      mismatched++;
      $display("FAIL digit_with_enter: got vv=%b count=%0d, required 1 1", value_valid, digit_count);
    end
    release_value();
  endtask

  task automatic test_err();
    exp_q.push_back('{14'd75, 3'd2});
    send_digit(4'd7, 1'b0);
    send_digit(4'd12, 1'b0);
    @(negedge clk);
    compared++;
    if (err !== 1'b1 || digit_count !== 3'd1) begin
      mismatched++;
      $display("FAIL err_pulse: got err=%b count=%0d, required 1 1", err, digit_count);
    end
    send_digit(4'd5, 1'b0);
    @(negedge clk);
    compared++;
    if (err !== 1'b0) begin
      mismatched++;
      $display("FAIL err_single_cycle: got err=%b, required 0", err);
    end
    pulse_enter();
    @(negedge clk);
    release_value();
  endtask

  task automatic test_nines();
    exp_q.push_back('{14'h270F, 3'd4});
    for (int i = 0; i < 4; i++) send_digit(4'd9, 1'b0);
    digit_valid = 1'b1;
    digit       = 4'd3;
    repeat (3) @(negedge clk);
    compared++;
    if (digit_ready !== 1'b0 || digit_count !== 3'd4 || value !== 14'd9999 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL done_no_accept: got ready=%b count=%0d value=%0d err=%b, required 0 4 9999 0",
               digit_ready, digit_count, value, err);
    end
    digit_valid = 1'b0;
    release_value();
  endtask

  task automatic test_clear();
    send_digit(4'd3, 1'b0);
    send_digit(4'd1, 1'b0);
    digit_valid = 1'b1;
    digit       = 4'd8;
    clear       = 1'b1;
    @(posedge clk); #1;
    digit_valid = 1'b0;
    clear       = 1'b0;
    @(negedge clk);
    compared++;
    if (digit_count !== 3'd0 || value !== 14'd0 || err !== 1'b0 ||
        value_valid !== 1'b0 || digit_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL clear: got count=%0d value=%0d err=%b vv=%b ready=%b, required 0 0 0 0 1",
               digit_count, value, err, value_valid, digit_ready);
    end
    exp_q.push_back('{14'd6, 3'd1});
    send_digit(4'd6, 1'b1);
    @(negedge clk);
    release_value();
  endtask

  task automatic test_rst_in_done();
    exp_q.push_back('{14'd5, 3'd1});
    send_digit(4'd5, 1'b1);
    @(negedge clk);
    compared++;
    if (value_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL pre_rst_done: got vv=%b, required 1", value_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (value_valid !== 1'b0 || value !== 14'd0 || digit_count !== 3'd0 || digit_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_in_done: got vv=%b value=%0d count=%0d ready=%b, required 0 0 0 1",
               value_valid, value, digit_count, digit_ready);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back('{14'd8, 3'd1});
    exp_q.push_back('{14'd90, 3'd2});
    send_digit(4'd8, 1'b1);
    value_ready = 1'b1;
    @(posedge clk); #1;
    value_ready = 1'b0;
    send_digit(4'd9, 1'b0);
    send_digit(4'd0, 1'b1);
    @(negedge clk);
    release_value();
    repeat (2) @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL sb_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_four_digits();
    test_enter();
    test_err();
    test_nines();
    test_clear();
    test_rst_in_done();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
